// File: rtl/spi_frame_receiver_pkg.sv
// Shared definitions for the SPI frame receiver: FSM encoding and default field lengths.
package spi_frame_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DES,
        ST_DATA,
        ST_CHK,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_SIZE     = 8;
    localparam int unsigned DEF_CHK_W    = 16;
    localparam int unsigned DEF_SYNC_LEN = 2;

    // Width of a counter that must hold values 0..max_bits.
    function automatic int unsigned cnt_width(input int unsigned max_bits);
        return (max_bits < 2) ? 1 : $clog2(max_bits + 1);
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall detection on the synced value.
module spi_input_sync #(
    parameter int unsigned SYNC_LEN  = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_LEN-1:0] stages;
    logic                prev;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stages <= {SYNC_LEN{RESET_VAL}};
            prev   <= RESET_VAL;
        end else begin
            stages <= {stages[SYNC_LEN-2:0], din};
            prev   <= stages[SYNC_LEN-1];
        end
    end

    assign sync = stages[SYNC_LEN-1];
    assign rise = sync && !prev;
    assign fall = !sync && prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave that deserialises destination/data/checksum frames and drives the router's
// data bus and write strobes.
module spi_frame_receiver
    import spi_frame_receiver_pkg::*;
#(
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned CHK_W    = DEF_CHK_W,
    parameter int unsigned SYNC_LEN = DEF_SYNC_LEN
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sclk,
    input  logic          mosi,
    input  logic          csN,
    output logic [SIZE:0] routerData,
    output logic          writeDes,
    output logic          writeData,
    output logic          writeCheck,
    output logic          sendData,
    output logic          enable,
    output logic          frameError,
    output logic [7:0]    frameCount
);

    localparam int unsigned CNT_W = cnt_width(CHK_W);

    logic sclk_sync_unused, sclk_rise, sclk_fall_unused;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
    logic csn_sync, csn_rise, csn_fall;

    spi_input_sync #(.SYNC_LEN(SYNC_LEN), .RESET_VAL(1'b0)) u_sync_sclk (
        .clock(clock), .reset(reset), .din(sclk),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    spi_input_sync #(.SYNC_LEN(SYNC_LEN), .RESET_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .din(mosi),
        .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_input_sync #(.SYNC_LEN(SYNC_LEN), .RESET_VAL(1'b1)) u_sync_csn (
        .clock(clock), .reset(reset), .din(csN),
        .sync(csn_sync), .rise(csn_rise), .fall(csn_fall)
    );

    state_t           state_q, state_n;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_n;
    logic [CHK_W-2:0] shift_q;
    logic [CHK_W-1:0] shift_in;
    logic             overrun_q, overrun_n;
    logic [SIZE:0]    router_data_n;
    logic             des_n, data_n, chk_n, send_n, enable_n, error_n;
    logic [7:0]       count_n;
    logic             bit_take, field_last, chk_last, pad_ok;

    assign bit_take   = sclk_rise && !csn_sync;
    assign shift_in   = {shift_q, mosi_sync};
    assign field_last = (bit_cnt_q == CNT_W'(SIZE - 1));
    assign chk_last   = (bit_cnt_q == CNT_W'(CHK_W - 1));
    assign pad_ok     = (shift_in[CHK_W-1:SIZE+1] == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            overrun_q  <= 1'b0;
            routerData <= '0;
            writeDes   <= 1'b0;
            writeData  <= 1'b0;
            writeCheck <= 1'b0;
            sendData   <= 1'b0;
            enable     <= 1'b0;
            frameError <= 1'b0;
            frameCount <= '0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            overrun_q  <= overrun_n;
            if (bit_take) begin
                shift_q <= shift_in[CHK_W-2:0];
            end
            routerData <= router_data_n;
            writeDes   <= des_n;
            writeData  <= data_n;
            writeCheck <= chk_n;
            sendData   <= send_n;
            enable     <= enable_n;
            frameError <= error_n;
            frameCount <= count_n;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_n       = state_q;
        bit_cnt_n     = bit_cnt_q;
        overrun_n     = overrun_q;
        router_data_n = routerData;
        des_n         = 1'b0;
        data_n        = 1'b0;
        chk_n         = 1'b0;
        send_n        = 1'b0;
        error_n       = 1'b0;
        enable_n      = enable;
        count_n       = frameCount;

        // A deselect inside a field aborts the frame and takes priority over a completing bit.
        if ((state_q inside {ST_DES, ST_DATA, ST_CHK}) && csn_rise) begin
            error_n  = 1'b1;
            enable_n = 1'b0;
            state_n  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bit_cnt_n = '0;
                    overrun_n = 1'b0;
                    if (csn_fall) begin
                        state_n = ST_DES;
                    end
                end
                ST_DES, ST_DATA: begin
                    if (bit_take) begin
                        if (field_last) begin
                            bit_cnt_n     = '0;
                            router_data_n = {1'b0, shift_in[SIZE-1:0]};
                            if (state_q == ST_DES) begin
                                des_n    = 1'b1;
                                enable_n = 1'b1;
                                state_n  = ST_DATA;
                            end else begin
                                data_n  = 1'b1;
                                state_n = ST_CHK;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CHK: begin
                    if (bit_take) begin
                        if (chk_last) begin
                            bit_cnt_n = '0;
                            state_n   = ST_DONE;
                            if (pad_ok) begin
                                chk_n         = 1'b1;
                                router_data_n = shift_in[SIZE:0];
                                state_n       = ST_SEND;
                            end else begin
                                // Bad pad already reported; later extra bits are not a second error.
                                error_n   = 1'b1;
                                enable_n  = 1'b0;
                                overrun_n = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    send_n  = 1'b1;
                    count_n = frameCount + 8'd1;
                    state_n = ST_DONE;
                end
                ST_DONE: begin
                    enable_n = 1'b0;
                    if (csn_sync) begin
                        state_n = ST_IDLE;
                    end else if (bit_take && !overrun_q) begin
                        error_n   = 1'b1;
                        overrun_n = 1'b1;
                    end
                end
                default: begin
                    state_n  = ST_IDLE;
                    enable_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: randomized frames against an event-level frame model.
module tb_spi_frame_receiver;

    localparam int SIZE     = 8;
    localparam int CHK_W    = 16;
    localparam int SYNC_LEN = 2;
    localparam int HALF     = 4;   // sclk half period in system clocks (sclk = clock/8)

    typedef enum int {EV_DES, EV_DATA, EV_CHK, EV_SEND, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [8:0] value;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sclk  = 1'b0;
    logic          mosi  = 1'b0;
    logic          csN   = 1'b1;
    logic [SIZE:0] routerData;
    logic          writeDes, writeData, writeCheck, sendData, enable, frameError;
    logic [7:0]    frameCount;

    int   n_checks = 0;
    int   n_errors = 0;
    int   model_count = 0;
    int   cycle = 0;
    int   mark_rise_cycle = 0;
    int   des_cycle = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  exp_ev;
    logic wc_d = 1'b0;
    logic sd_d = 1'b0;

    spi_frame_receiver #(.SIZE(SIZE), .CHK_W(CHK_W), .SYNC_LEN(SYNC_LEN)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .csN(csN),
        .routerData(routerData), .writeDes(writeDes), .writeData(writeData),
        .writeCheck(writeCheck), .sendData(sendData), .enable(enable),
        .frameError(frameError), .frameCount(frameCount)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Scoreboard: every strobe or error seen on the router side is matched against the model.
    always @(negedge clock) begin
        if (reset) begin
            obs_q = {};
            if (writeDes)   obs_q.push_back('{EV_DES, routerData});
            if (writeData)  obs_q.push_back('{EV_DATA, routerData});
            if (writeCheck) obs_q.push_back('{EV_CHK, routerData});
            if (sendData)   obs_q.push_back('{EV_SEND, routerData});
            if (frameError) obs_q.push_back('{EV_ERR, 9'h000});
            if (writeDes) des_cycle = cycle;

            if (writeDes || writeData || writeCheck || sendData) begin
                n_checks++;
                if ((int'(writeDes) + int'(writeData) + int'(writeCheck) + int'(sendData)) != 1) begin
                    n_errors++;
                    $display("FAIL one_hot: strobes des/data/chk/send = %b%b%b%b, required exactly one",
                             writeDes, writeData, writeCheck, sendData);
                end
                n_checks++;
                if (enable !== 1'b1) begin
                    n_errors++;
                    $display("FAIL enable_with_strobe: enable=%b, required 1", enable);
                end
            end
            if (wc_d || sendData) begin
                n_checks++;
                if (sendData !== wc_d) begin
                    n_errors++;
                    $display("FAIL send_timing: sendData=%b, writeCheck previous cycle=%b, required equal",
                             sendData, wc_d);
                end
            end
            if (sd_d) begin
                n_checks++;
                if (enable !== 1'b0) begin
                    n_errors++;
                    $display("FAIL enable_drop: enable=%b in cycle after sendData, required 0", enable);
                end
            end
            if (frameError) begin
                n_checks++;
                if (enable !== 1'b0) begin
                    n_errors++;
                    $display("FAIL enable_on_error: enable=%b with frameError, required 0", enable);
                end
            end
            foreach (obs_q[i]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard: got %s 0x%03h, required no event",
                             obs_q[i].kind.name(), obs_q[i].value);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (exp_ev.kind != obs_q[i].kind ||
                        (exp_ev.kind != EV_ERR && exp_ev.value !== obs_q[i].value)) begin
                        n_errors++;
                        $display("FAIL scoreboard: got %s 0x%03h, required %s 0x%03h",
                                 obs_q[i].kind.name(), obs_q[i].value,
                                 exp_ev.kind.name(), exp_ev.value);
                    end
                end
            end
            wc_d = writeCheck;
            sd_d = sendData;
        end else begin
            wc_d = 1'b0;
            sd_d = 1'b0;
        end
    end

    // Frame-level model: which router events one chip-select period of nbits bits must produce.
    function automatic void model_frame(input logic [31:0] frame, input int nbits);
        logic [7:0]  des;
        logic [7:0]  data;
        logic [15:0] chk;
        des  = frame[31:24];
        data = frame[23:16];
        chk  = frame[15:0];
        if (nbits >= 8)  exp_q.push_back('{EV_DES, {1'b0, des}});
        if (nbits >= 16) exp_q.push_back('{EV_DATA, {1'b0, data}});
        if (nbits < 32) begin
            exp_q.push_back('{EV_ERR, 9'h000});
        end else if (chk[15:9] != 7'd0) begin
            exp_q.push_back('{EV_ERR, 9'h000});
        end else begin
            exp_q.push_back('{EV_CHK, chk[8:0]});
            exp_q.push_back('{EV_SEND, chk[8:0]});
            model_count = (model_count + 1) % 256;
            if (nbits > 32) exp_q.push_back('{EV_ERR, 9'h000});
        end
    endfunction

    function automatic logic [31:0] rand_good();
        logic [31:0] f;
        f = $urandom;
        f[15:9] = 7'd0;
        return f;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Master: csN low, then nbits mode-0 bits, MSB first; bits past 32 are random filler.
    task automatic drive_bits(input logic [31:0] frame, input int nbits);
        csN = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) mosi = frame[31-i];
            else        mosi = 1'($urandom_range(0, 1));
            wait_clks(HALF);
            sclk = 1'b1;
            if (i == SIZE - 1) mark_rise_cycle = cycle;
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        wait_clks(HALF);
        csN = 1'b1;
        wait_clks(4 * HALF);
    endtask

    task automatic run_frame(input string name, input logic [31:0] frame, input int nbits);
        model_frame(frame, nbits);
        drive_bits(frame, nbits);
        end_frame();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_missing: %0d events still outstanding (next %s), required 0",
                     name, exp_q.size(), exp_q[0].kind.name());
            exp_q.delete();
        end
        n_checks++;
        if (frameCount !== 8'(model_count)) begin
            n_errors++;
            $display("FAIL %s_count: frameCount=%0d, required %0d", name, frameCount, model_count);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        csN   = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        wait_clks(3);
        reset = 1'b1;
        model_count = 0;
        wait_clks(4);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clks(3);
        n_checks++;
        if ({routerData, writeDes, writeData, writeCheck, sendData, enable, frameError, frameCount} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: data=0x%03h strobes=%b%b%b%b en=%b err=%b cnt=%0d, required all 0",
                     routerData, writeDes, writeData, writeCheck, sendData, enable, frameError, frameCount);
        end
        reset = 1'b1;
        model_count = 0;
        wait_clks(8);
        n_checks++;
        if ({routerData, writeDes, writeData, writeCheck, sendData, enable, frameError, frameCount} !== '0) begin
            n_errors++;
            $display("FAIL idle_outputs: data=0x%03h en=%b err=%b cnt=%0d, required all 0",
                     routerData, enable, frameError, frameCount);
        end
    endtask

    task automatic test_nominal();
        run_frame("nominal", 32'h01_80_0081, 32);
        n_checks++;
        if (routerData !== 9'h081) begin
            n_errors++;
            $display("FAIL nominal_hold: routerData=0x%03h, required 0x081", routerData);
        end
        n_checks++;
        if ((des_cycle - mark_rise_cycle) < 1 || (des_cycle - mark_rise_cycle) > SYNC_LEN + 2) begin
            n_errors++;
            $display("FAIL nominal_latency: writeDes %0d clocks after sclk edge, required 1..%0d",
                     des_cycle - mark_rise_cycle, SYNC_LEN + 2);
        end
        run_frame("nominal_rand", rand_good(), 32);
    endtask

    task automatic test_abort();
        logic [31:0] f;
        f = $urandom;
        f[31:24] = 8'hAA;
        run_frame("abort12", f, 12);
        run_frame("abort_next", rand_good(), 32);
        run_frame("abort0", rand_good(), 0);
        run_frame("abort16", rand_good(), 16);
        run_frame("abort_after", rand_good(), 32);
    endtask

    task automatic test_bad_pad();
        logic [31:0] f;
        f = $urandom;
        f[15:0] = 16'h8081;
        run_frame("bad_pad", f, 32);
        f = $urandom;
        f[15:9] = 7'($urandom_range(1, 127));
        run_frame("bad_pad_rand", f, 32);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] f;
        f = rand_good();
        exp_q.push_back('{EV_DES, {1'b0, f[31:24]}});
        exp_q.push_back('{EV_DATA, {1'b0, f[23:16]}});
        drive_bits(f, 20);
        reset = 1'b0;
        csN   = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({routerData, writeDes, writeData, writeCheck, sendData, enable, frameError, frameCount} !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: data=0x%03h en=%b err=%b cnt=%0d, required all 0",
                     routerData, enable, frameError, frameCount);
        end
        @(negedge clock);
        reset = 1'b1;
        model_count = 0;
        wait_clks(4 * HALF);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL midreset_missing: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        run_frame("midreset_next", rand_good(), 32);
    endtask

    task automatic test_overrun();
        run_frame("overrun", rand_good(), 40);
        run_frame("overrun_next", rand_good(), 32);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 256; k++) begin
            run_frame("stress", rand_good(), 32);
        end
        n_checks++;
        if (frameCount !== 8'd0) begin
            n_errors++;
            $display("FAIL stress_wrap: frameCount=%0d after 256 frames, required 0", frameCount);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_abort();
        test_bad_pad();
        test_reset_mid_frame();
        test_overrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
